// File: rtl/load_store_unit_pkg.sv
// load_store_unit_pkg: funct3 access encodings, FSM states and timeout default for the load/store unit
package load_store_unit_pkg;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam int unsigned TIMEOUT_DEFAULT = 16;
    typedef enum logic [1:0] {IDLE, BUS, DONE} lsu_state_t;
endpackage

// File: rtl/load_store_unit_if.sv
// load_store_unit_if: ready/valid data-memory bus between the load/store unit and memory
interface load_store_unit_if;
    logic        mem_valid;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    modport master (output mem_valid, mem_we, mem_addr, mem_be, mem_wdata, input mem_ready, mem_rdata);
    modport slave  (input mem_valid, mem_we, mem_addr, mem_be, mem_wdata, output mem_ready, mem_rdata);
endinterface

// File: rtl/load_store_unit_align.sv
// lsu_align: store byte-enable/lane replication, load extract/extend and access fault decode
module lsu_align import load_store_unit_pkg::*; (
    input  logic [2:0]  st_f3,
    input  logic [1:0]  st_off,
    input  logic [31:0] st_data,
    input  logic [2:0]  ld_f3,
    input  logic [1:0]  ld_off,
    input  logic [31:0] ld_word,
    output logic [3:0]  be,
    output logic [31:0] lanes,
    output logic [31:0] ldata,
    output logic        bad
);
    logic [7:0]  b;
    logic [15:0] h;
    always_comb begin
        b     = ld_word[8*ld_off +: 8];
        h     = ld_off[1] ? ld_word[31:16] : ld_word[15:0];
        be    = st_f3[1:0] == 2'b00 ? 4'b0001 << st_off : st_f3[1:0] == 2'b01 ? 4'b0011 << st_off : 4'b1111;
        lanes = st_f3[1:0] == 2'b00 ? {4{st_data[7:0]}} : st_f3[1:0] == 2'b01 ? {2{st_data[15:0]}} : st_data;
        ldata = ld_f3 == F3_B  ? {{24{b[7]}}, b} :
                ld_f3 == F3_H  ? {{16{h[15]}}, h} :
                ld_f3 == F3_BU ? {24'd0, b} :
                ld_f3 == F3_HU ? {16'd0, h} : ld_word;
        bad   = st_f3 == 3'b011 || st_f3 == 3'b110 || st_f3 == 3'b111 ||
                (st_f3[1:0] == 2'b01 && st_off[0]) || (st_f3[1:0] == 2'b10 && st_off != 2'b00);
    end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: multi-cycle load/store stage on a ready/valid bus; LSU_TIMEOUT_EN adds a BUS-state abort timer
module load_store_unit import load_store_unit_pkg::*;
`ifdef LSU_TIMEOUT_EN
#(parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT)
`endif
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_read,
    input  logic        req_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        load_done,
    output logic        fault,
    output logic        bus_err,
    load_store_unit_if.master bus
);
    lsu_state_t  state_q, state_d;
    logic        valid_q, valid_d, we_q, we_d, aborted;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic [3:0]  be_q, be_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  off_q, off_d;
    logic [3:0]  be;
    logic [31:0] lanes, ldata;
    logic        bad, req, go;
`ifdef LSU_TIMEOUT_EN
    logic [31:0] cnt_q, cnt_d;
    logic        err_q, err_d;
    assign aborted = err_q;
`else
    assign aborted = 1'b0;
`endif
    lsu_align u_align (
        .st_f3(funct3), .st_off(addr[1:0]), .st_data(wdata),
        .ld_f3(f3_q), .ld_off(off_q), .ld_word(bus.mem_rdata),
        .be(be), .lanes(lanes), .ldata(ldata), .bad(bad)
    );
    always_comb begin
        req       = req_read | req_write;
        go        = state_q == IDLE && req && !bad;
        fault     = state_q == IDLE && req && bad;
        stall     = go || state_q == BUS;
        rdata     = fault ? 32'd0 : rdata_q;
        load_done = state_q == DONE && !we_q && !aborted;
        bus_err   = state_q == DONE && aborted;
        state_d   = state_q;
        valid_d   = valid_q;
        we_d      = we_q;
        addr_d    = addr_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        f3_d      = f3_q;
        off_d     = off_q;
        rdata_d   = fault ? 32'd0 : rdata_q;
`ifdef LSU_TIMEOUT_EN
        err_d     = err_q;
        cnt_d     = state_q == BUS ? cnt_q + 32'd1 : 32'd0;
`endif
        case (state_q)
            IDLE: if (go) begin
                state_d = BUS;
                valid_d = 1'b1;
                we_d    = req_write;
                addr_d  = {addr[31:2], 2'b00};
                be_d    = be;
                wdata_d = lanes;
                f3_d    = funct3;
                off_d   = addr[1:0];
`ifdef LSU_TIMEOUT_EN
                err_d   = 1'b0;
`endif
            end
            BUS: if (bus.mem_ready) begin
                state_d = DONE;
                valid_d = 1'b0;
                rdata_d = we_q ? rdata_q : ldata;
            end
`ifdef LSU_TIMEOUT_EN
            else if (cnt_q == TIMEOUT_CYCLES - 1) begin
                state_d = DONE;
                valid_d = 1'b0;
                err_d   = 1'b1;
                rdata_d = 32'd0;
            end
`endif
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            be_q    <= 4'd0;
            wdata_q <= 32'd0;
            f3_q    <= 3'd0;
            off_q   <= 2'd0;
            rdata_q <= 32'd0;
`ifdef LSU_TIMEOUT_EN
            cnt_q   <= 32'd0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            f3_q    <= f3_d;
            off_q   <= off_d;
            rdata_q <= rdata_d;
`ifdef LSU_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end
    assign bus.mem_valid = valid_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_be    = be_q;
    assign bus.mem_wdata = wdata_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed table, corner sequences and randomized accesses against a reference model
module tb_load_store_unit;
    logic        clk = 1'b0, rst = 1'b1;
    logic        req_read = 1'b0, req_write = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] addr = 32'd0, wdata = 32'd0;
    logic        stall, load_done, fault, bus_err;
    logic [31:0] rdata;
    int          n_chk = 0, n_fail = 0;
    logic [31:0] last_rdata = 32'd0;
    load_store_unit_if bus();
`ifdef LSU_TIMEOUT_EN
    load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
`else
    load_store_unit dut (
`endif
        .clk(clk), .rst(rst), .req_read(req_read), .req_write(req_write), .funct3(funct3),
        .addr(addr), .wdata(wdata), .stall(stall), .rdata(rdata), .load_done(load_done),
        .fault(fault), .bus_err(bus_err), .bus(bus)
    );
    always #5 clk = ~clk;

    typedef struct {
        logic        rd, wr;
        logic [2:0]  f3;
        logic [31:0] a, wd, word;
        int          k;
        logic        x_fault;
        logic [3:0]  x_be;
        logic [31:0] x_wd, x_ld;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: size in bytes, natural alignment, lane arithmetic by byte index
    function automatic void model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                                  input logic [31:0] word, output logic flt, output logic [3:0] be,
                                  output logic [31:0] lanes, output logic [31:0] ld);
        int n, off;
        longint v;
        off = int'(a[1:0]);
        case (f3)
            3'b000, 3'b100: n = 1;
            3'b001, 3'b101: n = 2;
            3'b010:         n = 4;
            default:        n = 0;
        endcase
        flt = (n == 0) || (off % n != 0);
        if (n == 0) n = 4;
        be = 4'(((1 << n) - 1) << off);
        for (int i = 0; i < 4; i++) lanes[8*i +: 8] = wd[8*(i % n) +: 8];
        v = (longint'(word) >> (8 * off)) & ((64'sd1 << (8 * n)) - 1);
        if (!f3[2] && n < 4 && v >= (64'sd1 << (8 * n - 1))) v = v - (64'sd1 << (8 * n));
        ld = v[31:0];
    endfunction

    task automatic txn(input vec_t t, input string tag);
        @(negedge clk);
        req_read = t.rd; req_write = t.wr; funct3 = t.f3; addr = t.a; wdata = t.wd;
        bus.mem_ready = 1'b0;
        #1;
        chk({tag, "_fault"}, fault, t.x_fault);
        if (t.x_fault) begin
            chk({tag, "_fault_stall"}, stall, 0);
            chk({tag, "_fault_rdata"}, rdata, 0);
            @(negedge clk);
            chk({tag, "_fault_novalid"}, bus.mem_valid, 0);
            req_read = 1'b0; req_write = 1'b0;
            last_rdata = 32'd0;
            return;
        end
        chk({tag, "_stall_idle"}, stall, 1);
        for (int j = 1; j <= t.k; j++) begin
            @(negedge clk);
            chk({tag, "_stall_bus"}, stall, 1);
            chk({tag, "_valid"}, bus.mem_valid, 1);
            chk({tag, "_maddr"}, bus.mem_addr, {t.a[31:2], 2'b00});
            chk({tag, "_we"}, bus.mem_we, t.wr);
            if (t.wr) begin
                chk({tag, "_be"}, bus.mem_be, t.x_be);
                chk({tag, "_wdata"}, bus.mem_wdata, t.x_wd);
            end
            if (j == t.k) begin bus.mem_ready = 1'b1; bus.mem_rdata = t.word; end
        end
        @(negedge clk);
        bus.mem_ready = 1'b0;
        bus.mem_rdata = $urandom;
        chk({tag, "_stall_done"}, stall, 0);
        chk({tag, "_valid_done"}, bus.mem_valid, 0);
        chk({tag, "_load_done"}, load_done, !t.wr);
        if (!t.wr) last_rdata = t.x_ld;
        chk({tag, "_rdata"}, rdata, last_rdata);
        req_read = 1'b0; req_write = 1'b0;
        @(negedge clk);
        chk({tag, "_pulse_end"}, load_done, 0);
        chk({tag, "_rdata_hold"}, rdata, last_rdata);
    endtask

    vec_t tab[12];
    vec_t r;
    int   cnt;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        tab[0]  = '{0, 1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0,        2, 0, 4'b1111, 32'hDEADBEEF, 32'h0};
        tab[1]  = '{0, 1, 3'b000, 32'h13, 32'h000000A5, 32'h0,        1, 0, 4'b1000, 32'hA5A5A5A5, 32'h0};
        tab[2]  = '{1, 0, 3'b000, 32'h21, 32'h0,        32'h123480FF, 1, 0, 4'b0000, 32'h0,        32'hFFFFFF80};
        tab[3]  = '{1, 0, 3'b100, 32'h21, 32'h0,        32'h123480FF, 2, 0, 4'b0000, 32'h0,        32'h00000080};
        tab[4]  = '{1, 0, 3'b001, 32'h22, 32'h0,        32'h80010000, 1, 0, 4'b0000, 32'h0,        32'hFFFF8001};
        tab[5]  = '{1, 0, 3'b010, 32'h06, 32'h0,        32'h0,        1, 1, 4'b0000, 32'h0,        32'h0};
        tab[6]  = '{0, 1, 3'b001, 32'h12, 32'h1234ABCD, 32'h0,        1, 0, 4'b1100, 32'hABCDABCD, 32'h0};
        tab[7]  = '{1, 0, 3'b101, 32'h22, 32'h0,        32'h80010000, 3, 0, 4'b0000, 32'h0,        32'h00008001};
        tab[8]  = '{1, 0, 3'b011, 32'h00, 32'h0,        32'h0,        1, 1, 4'b0000, 32'h0,        32'h0};
        tab[9]  = '{1, 1, 3'b010, 32'h04, 32'h11223344, 32'h0,        3, 0, 4'b1111, 32'h11223344, 32'h0};
        tab[10] = '{1, 0, 3'b010, 32'h08, 32'h0,        32'hCAFEF00D, 1, 0, 4'b0000, 32'h0,        32'hCAFEF00D};
        tab[11] = '{0, 1, 3'b001, 32'h01, 32'h0000BEEF, 32'h0,        1, 1, 4'b0000, 32'h0,        32'h0};
        bus.mem_ready = 1'b0; bus.mem_rdata = 32'd0;
        #2;
        chk("rst_valid", bus.mem_valid, 0);
        chk("rst_we", bus.mem_we, 0);
        chk("rst_be", bus.mem_be, 0);
        chk("rst_addr", bus.mem_addr, 0);
        chk("rst_wdata", bus.mem_wdata, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_load_done", load_done, 0);
        chk("rst_bus_err", bus_err, 0);
        chk("rst_stall", stall, 0);
        @(negedge clk); rst = 1'b0;
        foreach (tab[i]) txn(tab[i], $sformatf("vec%0d", i));

        // reset in the middle of a bus transaction drops it at once
        @(negedge clk);
        req_read = 1'b1; funct3 = 3'b010; addr = 32'h08;
        @(negedge clk);
        chk("rstbus_valid_before", bus.mem_valid, 1);
        req_read = 1'b0; rst = 1'b1;
        #1;
        chk("rstbus_valid", bus.mem_valid, 0);
        chk("rstbus_stall", stall, 0);
        chk("rstbus_rdata", rdata, 0);
        @(negedge clk); rst = 1'b0; last_rdata = 32'd0;
        r = '{1, 0, 3'b010, 32'h08, 32'h0, 32'h0BADCAFE, 2, 0, 4'b0, 32'h0, 32'h0};
        model(r.f3, r.a, r.wd, r.word, r.x_fault, r.x_be, r.x_wd, r.x_ld);
        txn(r, "after_rst");

        // bus never answers
        @(negedge clk);
        req_read = 1'b1; funct3 = 3'b010; addr = 32'h0C; bus.mem_ready = 1'b0;
        cnt = 0;
`ifdef LSU_TIMEOUT_EN
        for (int j = 0; j < 40; j++) begin
            #1;
            if (!stall) break;
            cnt++;
            @(negedge clk);
        end
        chk("timeout_stall_cycles", cnt, 5);
        chk("timeout_bus_err", bus_err, 1);
        chk("timeout_rdata", rdata, 0);
        chk("timeout_load_done", load_done, 0);
        req_read = 1'b0;
        @(negedge clk);
        chk("timeout_err_pulse", bus_err, 0);
        last_rdata = 32'd0;
`else
        for (int j = 0; j < 30; j++) begin
            #1;
            if (stall && (j == 0 || bus.mem_valid)) cnt++;
            @(negedge clk);
        end
        chk("hang_stall_cycles", cnt, 30);
        chk("hang_bus_err", bus_err, 0);
        req_read = 1'b0; rst = 1'b1;
        @(negedge clk); rst = 1'b0; last_rdata = 32'd0;
`endif

        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(2))
                0: begin r.rd = 1; r.wr = 0; end
                1: begin r.rd = 0; r.wr = 1; end
                default: begin r.rd = 1; r.wr = 1; end
            endcase
            r.f3 = 3'($urandom_range(7));
            r.a = $urandom; r.wd = $urandom; r.word = $urandom;
            r.k = $urandom_range(1, 4);
            model(r.f3, r.a, r.wd, r.word, r.x_fault, r.x_be, r.x_wd, r.x_ld);
            txn(r, $sformatf("rnd%0d", i));
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
